// File: rtl/mc_pkg.sv
// mc_pkg: shared states, opcodes and mux-select constants for the multicycle control FSM
package mc_pkg;
  typedef enum logic [3:0] {
    RST_WAIT, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, EXEC_I, ALUWB, BRANCH, TRAP
  } state_t;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  function automatic state_t decode_next(input logic [6:0] op);
    return (op == OP_R) ? EXEC_R :
           (op == OP_I) ? EXEC_I :
           (op == OP_LD || op == OP_ST) ? MEMADR :
           (op == OP_BR) ? BRANCH : TRAP;
  endfunction
endpackage

// File: rtl/mc_retire_counter.sv
// mc_retire_counter: wrapping retired-instruction counter with async reset
module mc_retire_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);
  logic [CNT_W-1:0] count_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) count_q <= '0;
    else if (inc_i) count_q <= count_q + CNT_W'(1);
  assign count_o = count_q;
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: RV32I multicycle main control FSM with memory handshake and retire count
module multicycle_control
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IorD,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             PCSource,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUop,
  output logic             funct30_mask,
  output logic             RegWrite,
  output logic             MemtoReg,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);
  state_t state_q, state_d;
  logic   retire;
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= RST_WAIT;
    else state_q <= state_d;
  always_comb begin
    state_d      = state_q;
    mem_req      = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    IorD         = 1'b0;
    IRWrite      = 1'b0;
    PCWrite      = 1'b0;
    PCWriteCond  = 1'b0;
    PCSource     = 1'b0;
    ALUSrcA      = SRCA_PC;
    ALUSrcB      = SRCB_REG;
    ALUop        = ALUOP_ADD;
    funct30_mask = 1'b0;
    RegWrite     = 1'b0;
    MemtoReg     = 1'b0;
    illegal      = 1'b0;
    retire       = 1'b0;
    case (state_q)
      RST_WAIT: state_d = FETCH;
      FETCH: begin
        mem_req = 1'b1;
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        state_d = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        state_d = decode_next(opcode);
      end
      EXEC_R: begin
        ALUSrcA = SRCA_REG;
        ALUop   = ALUOP_FUNCT;
        state_d = ALUWB;
      end
      EXEC_I: begin
        ALUSrcA      = SRCA_REG;
        ALUSrcB      = SRCB_IMM;
        ALUop        = ALUOP_FUNCT;
        funct30_mask = 1'b1;
        state_d      = ALUWB;
      end
      ALUWB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
        state_d  = FETCH;
      end
      MEMADR: begin
        ALUSrcA = SRCA_REG;
        ALUSrcB = SRCB_IMM;
        state_d = (opcode == OP_LD) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        mem_req = 1'b1;
        MemRead = 1'b1;
        IorD    = 1'b1;
        state_d = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        retire   = 1'b1;
        state_d  = FETCH;
      end
      MEMWR: begin
        mem_req  = 1'b1;
        MemWrite = 1'b1;
        IorD     = 1'b1;
        retire   = mem_ready;
        state_d  = mem_ready ? FETCH : MEMWR;
      end
      BRANCH: begin
        ALUSrcA     = SRCA_REG;
        ALUop       = ALUOP_BR;
        PCWriteCond = 1'b1;
        PCSource    = 1'b1;
        retire      = 1'b1;
        state_d     = FETCH;
      end
      TRAP: illegal = 1'b1;
      default: state_d = RST_WAIT;
    endcase
  end
  mc_retire_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .inc_i  (retire),
    .count_o(retired)
  );
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle RV32I core. It sequences fetch, decode, execute, memory and write-back over several cycles and drives every datapath enable and mux select. It produces the 2-bit ALUop consumed by the ALU control decoder. It also stalls on a ready/request memory handshake and counts retired instructions.

## Interface
Parameters:
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- opcode  in  7  instr[6:0] from the instruction register (valid from DECODE onward)
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request active
- MemRead  out  1  read strobe (with mem_req)
- MemWrite  out  1  write strobe (with mem_req)
- IorD  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory
- IRWrite  out  1  latch instruction register and oldPC
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load qualified by the branch-taken result
- PCSource  out  1  0 = ALU result, 1 = ALUOut
- ALUSrcA  out  2  00 PC, 01 oldPC, 10 register A
- ALUSrcB  out  2  00 register B, 01 constant 4, 10 immediate
- ALUop  out  2  00 add, 01 branch compare, 10 funct decode
- funct30_mask  out  1  datapath forces funct[3]=0 (I-type ALU)
- RegWrite  out  1  register file write
- MemtoReg  out  1  0 = ALUOut, 1 = MDR
- illegal  out  1  sticky unsupported-opcode flag
- retired  out  CNT_W  retired-instruction count

## Operation
- States (encoded in the package): RST_WAIT, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, EXEC_I, ALUWB, BRANCH, TRAP.
- Any output not listed for a state is 0.
- RST_WAIT: all outputs 0. Goes to FETCH after one cycle.
- FETCH: mem_req=1, MemRead=1, IorD=0, ALUSrcA=00, ALUSrcB=01, ALUop=00.
  - IRWrite and PCWrite assert only in the cycle mem_ready=1; the FSM moves to DECODE in that cycle.
  - The FSM holds in FETCH while mem_ready=0.
- DECODE: ALUSrcA=01, ALUSrcB=10, ALUop=00 (branch target into ALUOut). Next state by opcode:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0000011 or 0100011 → MEMADR
  - 1100011 → BRANCH
  - any other opcode → TRAP
- EXEC_R: ALUSrcA=10, ALUSrcB=00, ALUop=10 → ALUWB.
- EXEC_I: ALUSrcA=10, ALUSrcB=10, ALUop=10, funct30_mask=1 → ALUWB.
- ALUWB: RegWrite=1, MemtoReg=0 → FETCH; retires.
- MEMADR: ALUSrcA=10, ALUSrcB=10, ALUop=00. Goes to MEMRD for a load, MEMWR for a store.
- MEMRD: mem_req=1, MemRead=1, IorD=1. Holds until mem_ready, then → MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1 → FETCH; retires.
- MEMWR: mem_req=1, MemWrite=1, IorD=1. Holds until mem_ready, then → FETCH; retires in the mem_ready cycle.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUop=01, PCWriteCond=1, PCSource=1 → FETCH; retires whether taken or not.
- TRAP: illegal=1, all strobes 0. Absorbing state; only reset exits.
- retired increments by 1 on each retiring cycle and wraps from 2^CNT_W−1 to 0.

## Timing
- Reset values: state=RST_WAIT, retired=0, illegal=0, all strobes 0. Reset asserted mid-instruction aborts immediately, with no partial RegWrite or MemWrite.
- All outputs except IRWrite and PCWrite are Moore (state only). IRWrite and PCWrite are state AND mem_ready.
- mem_req and the address selects stay stable while the FSM waits in FETCH, MEMRD or MEMWR.
- mem_ready is ignored in every state that does not assert mem_req.
- Latency with zero memory wait states:
  - R-type, I-type: 4 cycles
  - load: 5 cycles
  - store: 4 cycles
  - branch: 3 cycles
- Each memory wait cycle adds exactly 1 cycle.
- retired updates on the clock edge that leaves the retiring state. A new count is visible in the first FETCH cycle.

## Structure
- Package mc_pkg holds:
  - state enum
  - opcode constants (OP_R, OP_I, OP_LD, OP_ST, OP_BR)
  - ALUop constants (ALUOP_ADD=00, ALUOP_BR=01, ALUOP_FUNCT=10)
  - ALUSrcA/B select constants
- One sub-module, mc_retire_counter: CNT_W-wide counter with async reset and an inc input.
- The FSM keeps the next-state and output decode in the top-level module.

## Test plan
- Reset, release, mem_ready tied 1, opcode=0110011 → RST_WAIT, FETCH, DECODE, EXEC_R (ALUop=10), ALUWB (RegWrite=1); retired=1 in the next FETCH.
- Load with mem_ready low for 3 cycles in MEMRD → MEMRD lasts 4 cycles with mem_req, MemRead and IorD stable; MEMWB asserts MemtoReg=1; total 8 cycles.
- Branch opcode 1100011 → BRANCH asserts ALUop=01, PCWriteCond=1 and PCSource=1 for exactly one cycle; retired increments.
- Opcode 1111111 → TRAP; illegal=1 and no strobes for 20 cycles; reset clears illegal=0.
- Reset asserted during MEMWR with mem_ready=0 → MemWrite drops immediately; state=RST_WAIT; retired=0.
- With CNT_W=4, run 16 ALU instructions → retired wraps from 15 to 0.
